arbitro_rr_saida: RTL
=====================

# arbitro_rr_saida

Per-output-port round-robin arbiter with wormhole packet locking for the 5-port mesh router. One instance sits in front of each output port's crossbar mux. It picks one of the five input requesters (cima, baixo, esquerda, direita, local) and holds that grant for a whole packet, head through tail flit. Round-robin rotation replaces fixed priority so no input starves under sustained load.

## Interface
- `N_PORTAS`, 5: number of requesters; bit order fixed: 4=cima, 3=baixo, 2=esquerda, 1=direita, 0=local.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  5  per-input request; a flit is valid at that input's head.
- `tail`  in  5  per-input tail marker; qualified only by the matching `req` bit.
- `out_ready`  in  1  downstream can accept a flit this cycle (credit available).
- `grant`  out  5  registered one-hot grant to the crossbar mux and input buffers; all-zero when idle.
- `sel`  out  3  binary index of the granted input, 0..4; meaningful only while `busy`=1.
- `busy`  out  1  output port locked to a packet.

## Operation
- Two states: LIVRE (idle), TRAVADO (locked). Reset state is LIVRE.
- Internal pointer `ptr` (3 bits, 0..4) holds the index of the last winner.
- Transfer rule: a flit moves in any cycle where `grant[i]`=1, `req[i]`=1 and `out_ready`=1.
- LIVRE with `req`=0: stay. `grant`=0, `busy`=0.
- LIVRE with `req`!=0: pick winner w by searching indices ptr-1, ptr-2, … down to ptr, modulo 5 (ptr=0 searches 4,3,2,1,0). First set bit wins. Next cycle: `grant`=one-hot(w), `sel`=w, `busy`=1, state TRAVADO, `ptr`=w.
- TRAVADO: `grant`/`sel` hold regardless of other `req` bits. A transfer with `tail[w]`=1 releases the lock. Next cycle: state LIVRE, `grant`=0, `busy`=0.
- Granted `req[w]` dropping mid-packet (bubble) does not release. The lock holds until the tail transfer.
- `out_ready`=0 stalls: no transfer, and `tail` is ignored for release.
- `req`/`tail` on non-granted inputs are ignored while TRAVADO.
- Single-flit packet: head carries `tail`=1. Release on its transfer cycle.
- `ptr` updates only on a new grant, never on release.
- Illegal `ptr` values 5..7 are treated as 0.

## Timing
- Reset (async assert): `grant`=0, `sel`=0, `busy`=0, state LIVRE, `ptr`=0. Effective immediately, without a clock edge. Deassertion is used synchronously.
- Reset mid-packet aborts the lock. After reset, the first arbitration gives cima priority, matching the router's historical fixed order.
- Arbitration latency: `req` sampled in LIVRE at edge k gives `grant` valid after edge k+1.
- Tail transfer at cycle T: `grant`=0 in T+1. Arbitration is re-evaluated in T+1, and a new grant appears in T+2. Minimum inter-packet gap is one idle cycle on the output.
- `grant`, `sel`, `busy` are register outputs with no combinational path from inputs.
- Throughput while locked: one flit per cycle when `req[w]` and `out_ready` stay high.

## Structure
- Shared package `router_pkg`:
  - `N_PORTAS`=5.
  - Port index constants CIMA=4, BAIXO=3, ESQUERDA=2, DIREITA=1, LOCAL=0.
  - State enum {LIVRE, TRAVADO}.
  - One-hot/index conversion function. The existing fixed-priority arbiter and the crossbar mux reuse it.
- One combinational sub-module `seletor_rr` takes (`req`, `ptr`) and returns (winner one-hot, winner index, any).
- `arbitro_rr_saida` holds only the state, pointer and output registers.

## Test plan
- Reset, then `req`=5'b11111 held, `out_ready`=1, each head flit with `tail`=1 → grants in order 10000, 01000, 00100, 00010, 00001, 10000, each separated by one idle cycle.
- `req`=5'b00101, 4-flit packet from index 2 (`tail` on 4th transfer) → `grant`=00100 for exactly 4 transfer cycles with `req[0]` ignored; then 00001 after the one idle cycle.
- Locked to index 3, `out_ready` low for 3 cycles while `tail[3]`=1 → `grant` holds 01000 and `busy`=1 throughout; release only on the cycle after `out_ready` rises.
- Locked to index 1, `req[1]` drops for 2 cycles mid-packet, `req[4]` asserted → `grant` stays 00010 until the tail transfer; next winner is 4.
- Assert `rst_n`=0 mid-packet, asynchronously between edges → `grant`=0, `busy`=0 without a clock edge; after release with `req`=5'b00011, the first grant is 00010.
- `req`=0 for 10 cycles → `grant`=0, `busy`=0, `ptr` unchanged. A later `req`=5'b00001 → `grant`=00001 one cycle after sampling.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: port count, port index map, arbiter state
// encoding and one-hot/index conversion helpers.
package router_pkg;

  localparam int N_PORTAS = 5;

  localparam int CIMA     = 4;
  localparam int BAIXO    = 3;
  localparam int ESQUERDA = 2;
  localparam int DIREITA  = 1;
  localparam int LOCAL    = 0;

  typedef enum logic {
    LIVRE   = 1'b0,
    TRAVADO = 1'b1
  } estado_t;

  // Out-of-range indices give an all-zero vector.
  function automatic logic [N_PORTAS-1:0] indice_para_onehot(input logic [2:0] idx);
    logic [N_PORTAS-1:0] oh;
    oh = '0;
    if (idx < 3'(N_PORTAS)) oh[idx] = 1'b1;
    return oh;
  endfunction

  // Lowest set bit wins if more than one is set; all-zero maps to 0.
  function automatic logic [2:0] onehot_para_indice(input logic [N_PORTAS-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_PORTAS - 1; i >= 0; i--) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbitro_rr_saida_if.sv
// Requester/arbiter bundle for one output port, plus state/pointer debug taps.
interface arbitro_rr_saida_if;
  import router_pkg::*;

  // Handshake: a flit moves in any cycle where grant[i], req[i] and out_ready
  // are all high; tail[i] counts only on such a cycle. grant/sel/busy are
  // registered, so requesters may look at them without a combinational loop.
  logic [N_PORTAS-1:0] req;
  logic [N_PORTAS-1:0] tail;
  logic                out_ready;
  logic [N_PORTAS-1:0] grant;
  logic [2:0]          sel;
  logic                busy;
  estado_t             estado;
  logic [2:0]          ptr;

  modport master (
    output req, tail, out_ready,
    input  grant, sel, busy, estado, ptr
  );

  modport slave (
    input  req, tail, out_ready,
    output grant, sel, busy, estado, ptr
  );

endinterface

// File: rtl/arbitro_rr_saida_seletor_rr.sv
// Combinational round-robin pick: searches downward from the input just
// below the last winner, wrapping modulo N_PORTAS.
module seletor_rr
  import router_pkg::*;
(
  input  logic [N_PORTAS-1:0] req,
  input  logic [2:0]          ptr,
  output logic [N_PORTAS-1:0] vencedor_oh,
  output logic [2:0]          vencedor_idx,
  output logic                algum
);

  logic [2:0] base;

  assign base = (ptr >= 3'(N_PORTAS)) ? 3'd0 : ptr;

  always_comb begin
    logic [2:0] cand;
    cand         = 3'd0;
    vencedor_oh  = '0;
    algum        = 1'b0;
    // The last winner itself is the lowest-priority candidate.
    for (int k = 1; k <= N_PORTAS; k++) begin
      cand = 3'((int'(base) + N_PORTAS - k) % N_PORTAS);
      if (!algum && req[cand]) begin
        algum             = 1'b1;
        vencedor_oh[cand] = 1'b1;
      end
    end
    vencedor_idx = onehot_para_indice(vencedor_oh);
  end

endmodule

// File: rtl/arbitro_rr_saida.sv
// Output-port arbiter: round-robin grant held for a whole wormhole packet,
// released on the tail flit's transfer.
module arbitro_rr_saida
  import router_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  arbitro_rr_saida_if.slave  bus
);

  estado_t             estado_q, estado_d;
  logic [N_PORTAS-1:0] grant_q, grant_d;
  logic [2:0]          sel_q, sel_d;
  logic [2:0]          ptr_q, ptr_d;
  logic                busy_q, busy_d;

  logic [N_PORTAS-1:0] venc_oh;
  logic [2:0]          venc_idx;
  logic                algum;
  logic                transferencia;
  logic                liberar;

  seletor_rr u_seletor (
    .req          (bus.req),
    .ptr          (ptr_q),
    .vencedor_oh  (venc_oh),
    .vencedor_idx (venc_idx),
    .algum        (algum)
  );

  // grant_q is one-hot or zero, so masking picks only the owner's bits.
  assign transferencia = bus.out_ready && (|(grant_q & bus.req));
  assign liberar       = transferencia && (|(grant_q & bus.req & bus.tail));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= LIVRE;
      grant_q  <= '0;
      sel_q    <= 3'd0;
      ptr_q    <= 3'd0;
      busy_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    case (estado_q)
      LIVRE: begin
        if (algum) begin
          estado_d = TRAVADO;
          grant_d  = venc_oh;
          sel_d    = venc_idx;
          ptr_d    = venc_idx;
          busy_d   = 1'b1;
        end
      end
      TRAVADO: begin
        // Pointer is left alone on release; it only moves on a new grant.
        if (liberar) begin
          estado_d = LIVRE;
          grant_d  = '0;
          busy_d   = 1'b0;
        end
      end
    endcase
  end

  assign bus.grant  = grant_q;
  assign bus.sel    = sel_q;
  assign bus.busy   = busy_q;
  assign bus.estado = estado_q;
  assign bus.ptr    = ptr_q;

endmodule
